fir_sample_feeder: RTL and testbench
====================================

# fir_sample_feeder

Front end for the 8-tap `fir_filter`. It turns a serial sample stream with a valid/ready handshake into the 8-wide sliding window `x0..x7` that the filter consumes. It also holds the coefficient bank `coeff0..coeff7` with shadow/commit update, and produces the output-valid strobe that the filter itself lacks. It sits directly upstream of `fir_filter`, and its outputs wire 1:1 to the filter inputs.

## Interface
- `bit_width`, 16, sample and coefficient width (signed). Must match `fir_filter`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: feeder can accept a sample.
- `s_data` in `bit_width`: signed input sample.
- `coeff_we` in 1: write the shadow coefficient register.
- `coeff_addr` in 3: shadow index, 0..7.
- `coeff_wdata` in `bit_width`: shadow write data.
- `coeff_commit` in 1: request a copy of shadow into active.
- `coeff_pending` out 1: a commit is waiting for the pipeline to drain.
- `flush` in 1: one-cycle pulse that drains the window tail with zeros.
- `x0..x7` out `bit_width` each: window, registered. `x0` is the newest sample, `x7` the oldest.
- `coeff0..coeff7` out `bit_width` each: active coefficients, registered.
- `win_valid` out 1: the window changed this cycle and is complete.
- `y_valid` out 1: `fir_filter.y_out` holds a result for a valid window.

## Operation
- A sample is accepted when `s_valid && s_ready`. The window then shifts: `x0` takes `s_data`, and each `xk` takes `x(k-1)`.
- State FILL:
  - `s_ready` = 1 unless a commit is pending.
  - A 4-bit count tracks accepted samples.
  - On the 8th accepted sample the state moves to RUN, and `win_valid` pulses on the cycle after that shift.
- State RUN:
  - Every accepted sample produces a `win_valid` pulse on the next cycle.
  - `flush` moves the state to FLUSH, but only after any same-cycle accepted sample has shifted in.
- State FLUSH:
  - `s_ready` = 0.
  - The window shifts zeros in for exactly 7 consecutive cycles, each followed by a `win_valid` pulse.
  - The state then returns to FILL with count = 0 and all `x` cleared to 0.
- `flush` in FILL with count > 0:
  - The zero-shift repeats until the oldest real sample reaches `x7`, i.e. 8 − count shifts, with no `win_valid`.
  - After that it behaves as in RUN: 7 zero shifts with `win_valid`, then FILL.
- `flush` in FILL with count = 0 is ignored. `flush` during FLUSH is ignored.
- Shadow coefficients:
  - `coeff_we` writes `shadow[coeff_addr]` in any state.
  - `coeff_commit` sets `coeff_pending`, which forces `s_ready` = 0 and blocks FLUSH shifts.
  - Once the `y_valid` pipeline is empty and no `win_valid` is outstanding, all 8 active coefficients load from shadow in one cycle and `coeff_pending` clears.
  - A `coeff_we` in the same cycle as the copy is included in the copy (write-first).
- `y_valid` is `win_valid` delayed by a 4-stage shift register, matching the filter's mult → add → add → add latency.
- Arithmetic: no arithmetic is done here. Data widths pass through unchanged.

## Timing
- Reset values:
  - all `x`, `coeff`, and shadow registers = 0
  - `win_valid` = `y_valid` = `coeff_pending` = 0
  - `s_ready` = 1
  - state FILL, count = 0
- Acceptance at edge N: the new window is visible and `win_valid` = 1 in cycle N+1, and `y_valid` = 1 in cycle N+5.
- Sustained throughput is 1 sample per cycle with `s_valid` held high in RUN.
- A commit issued with an empty pipeline updates the active coefficients at the next edge. `coeff_pending` is high for exactly 1 cycle.
- Deasserting `rst_n` mid-stream or mid-flush aborts immediately. The `y_valid` pipeline is cleared, so no stale strobe appears.

## Configuration
- `FIR_FEEDER_FLUSH_EN`
  - Defined: FLUSH state and the `flush` port logic are present as specified.
  - Undefined: `flush` is ignored, there is no FLUSH state, and the window only advances on accepted samples.

## Structure
- Shared package `fir_pkg`:
  - state enum (FILL, RUN, FLUSH)
  - `FIR_TAPS` = 8
  - `FIR_PIPE_LAT` = 4
- One sub-module, `fir_valid_pipe`: a parameterised-depth valid delay line with synchronous clear. It generates `y_valid` and reports "pipe empty" for commit gating.

## Test plan
- Fill: feed samples 1..8 → no `win_valid` until the cycle after sample 8. Then `x0..x7` = 8,7,…,1 and `win_valid` = 1. `y_valid` = 1 four cycles later.
- Streaming: feed 9..12 back-to-back → `win_valid` = 1 for 4 consecutive cycles, and `x0` = 12 at the end.
- Flush (macro defined): after the stream, pulse `flush` → `s_ready` = 0 for 7 cycles, 7 `win_valid` pulses, `x7` takes 6 then 7…12 in turn, and the window ends all-zero in FILL.
- Commit under traffic:
  - Write shadow[3] = 0x0100, then commit while RUN is streaming.
  - `s_ready` drops, and `coeff3` = 0x0100 only after `y_valid` goes idle.
  - `coeff_pending` then clears.
- Same-cycle write + commit copy: `coeff_we` to addr 0 with 0x7FFF on the copy cycle → `coeff0` = 0x7FFF.
- Reset mid-flush: assert `rst_n` = 0 during FLUSH cycle 3 → all outputs return to their reset values, and no `y_valid` appears afterward.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR front end: tap count, filter latency and
// the feeder state encoding.
package fir_pkg;

  localparam int FIR_TAPS     = 8;
  localparam int FIR_PIPE_LAT = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } feed_state_t;

endpackage

// File: rtl/fir_valid_pipe.sv
// Valid-strobe delay line of configurable depth with synchronous clear and
// an "empty" flag covering every stage.
module fir_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_valid,
  output logic o_valid,
  output logic o_empty
);

  logic [DEPTH-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else if (i_clr) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], i_valid};
    end
  end

  assign o_valid = r_stage[DEPTH-1];
  assign o_empty = ~|r_stage;

endmodule

// File: rtl/fir_sample_feeder.sv
// Sliding-window sample feeder and shadow/commit coefficient bank for the
// 8-tap fir_filter. Define FIR_FEEDER_FLUSH_EN to include the flush drain.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int bit_width = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic signed [bit_width-1:0] s_data,
  input  logic                        coeff_we,
  input  logic [2:0]                  coeff_addr,
  input  logic signed [bit_width-1:0] coeff_wdata,
  input  logic                        coeff_commit,
  output logic                        coeff_pending,
  input  logic                        flush,
  output logic signed [bit_width-1:0] x0,
  output logic signed [bit_width-1:0] x1,
  output logic signed [bit_width-1:0] x2,
  output logic signed [bit_width-1:0] x3,
  output logic signed [bit_width-1:0] x4,
  output logic signed [bit_width-1:0] x5,
  output logic signed [bit_width-1:0] x6,
  output logic signed [bit_width-1:0] x7,
  output logic signed [bit_width-1:0] coeff0,
  output logic signed [bit_width-1:0] coeff1,
  output logic signed [bit_width-1:0] coeff2,
  output logic signed [bit_width-1:0] coeff3,
  output logic signed [bit_width-1:0] coeff4,
  output logic signed [bit_width-1:0] coeff5,
  output logic signed [bit_width-1:0] coeff6,
  output logic signed [bit_width-1:0] coeff7,
  output logic                        win_valid,
  output logic                        y_valid
);

  feed_state_t r_state, w_state_next;
  logic [3:0]  r_count, w_count_next;
  logic [3:0]  r_pre, w_pre_next;
  logic [2:0]  r_post, w_post_next;
  logic        r_clr, w_clr_next;
  logic        r_win_valid, w_win_next;
  logic        r_pending;
  logic        w_accept, w_shift, w_zero_in, w_copy, w_pipe_empty, w_flush_req;
  logic [3:0]  w_cnt_acc;

  logic signed [bit_width-1:0] r_x         [FIR_TAPS];
  logic signed [bit_width-1:0] w_tap_in    [FIR_TAPS];
  logic signed [bit_width-1:0] r_shadow    [FIR_TAPS];
  logic signed [bit_width-1:0] w_shadow_wr [FIR_TAPS];
  logic signed [bit_width-1:0] r_coeff     [FIR_TAPS];

`ifdef FIR_FEEDER_FLUSH_EN
  assign w_flush_req = flush;
`else
  logic w_unused_flush;
  assign w_flush_req    = 1'b0;
  assign w_unused_flush = flush;
`endif

  assign s_ready   = (r_state != FLUSH) && !r_pending;
  assign w_accept  = s_valid && s_ready;
  assign w_cnt_acc = r_count + {3'd0, w_accept};
  // Copy only once nothing computed with the old coefficients is in flight.
  assign w_copy    = r_pending && w_pipe_empty && !r_win_valid;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_pre_next   = r_pre;
    w_post_next  = r_post;
    w_clr_next   = 1'b0;
    w_win_next   = 1'b0;
    w_shift      = 1'b0;
    w_zero_in    = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          w_shift      = 1'b1;
          w_count_next = w_cnt_acc;
          if (r_count == 4'd7) begin
            w_state_next = RUN;
            w_win_next   = 1'b1;
          end
        end
        // Silent pre-shifts bring the oldest real sample to x7 first.
        if (w_flush_req && (w_cnt_acc != 4'd0)) begin
          w_state_next = FLUSH;
          w_pre_next   = w_cnt_acc[3] ? 4'd0 : (4'd8 - w_cnt_acc);
          w_post_next  = 3'd7;
        end
      end
      RUN: begin
        if (w_accept) begin
          w_shift    = 1'b1;
          w_win_next = 1'b1;
        end
        if (w_flush_req) begin
          w_state_next = FLUSH;
          w_pre_next   = 4'd0;
          w_post_next  = 3'd7;
        end
      end
`ifdef FIR_FEEDER_FLUSH_EN
      FLUSH: begin
        if (!r_pending) begin
          w_shift   = 1'b1;
          w_zero_in = 1'b1;
          if (r_pre != 4'd0) begin
            w_pre_next = r_pre - 4'd1;
          end else begin
            w_win_next  = 1'b1;
            w_post_next = r_post - 3'd1;
            if (r_post == 3'd1) begin
              w_state_next = FILL;
              w_count_next = 4'd0;
              w_clr_next   = 1'b1;
            end
          end
        end
      end
`endif
      default: w_state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FILL;
      r_count     <= 4'd0;
      r_pre       <= 4'd0;
      r_post      <= 3'd0;
      r_clr       <= 1'b0;
      r_win_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_count     <= w_count_next;
      r_pre       <= w_pre_next;
      r_post      <= w_post_next;
      r_clr       <= w_clr_next;
      r_win_valid <= w_win_next;
    end
  end

  genvar gi;
  assign w_tap_in[0] = w_zero_in ? '0 : s_data;
  generate
    for (gi = 1; gi < FIR_TAPS; gi++) begin : g_tap
      assign w_tap_in[gi] = r_x[gi-1];
    end
  endgenerate

  // The clear after a flush still lets a same-cycle sample land in x0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIR_TAPS; i++) r_x[i] <= '0;
    end else if (r_clr) begin
      for (int i = 1; i < FIR_TAPS; i++) r_x[i] <= '0;
      r_x[0] <= w_accept ? s_data : '0;
    end else if (w_shift) begin
      for (int i = 0; i < FIR_TAPS; i++) r_x[i] <= w_tap_in[i];
    end
  end

  always_comb begin
    for (int i = 0; i < FIR_TAPS; i++) w_shadow_wr[i] = r_shadow[i];
    if (coeff_we) w_shadow_wr[coeff_addr] = coeff_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIR_TAPS; i++) begin
        r_shadow[i] <= '0;
        r_coeff[i]  <= '0;
      end
      r_pending <= 1'b0;
    end else begin
      for (int i = 0; i < FIR_TAPS; i++) begin
        r_shadow[i] <= w_shadow_wr[i];
        if (w_copy) r_coeff[i] <= w_shadow_wr[i];
      end
      r_pending <= coeff_commit || (r_pending && !w_copy);
    end
  end

  fir_valid_pipe #(
    .DEPTH (FIR_PIPE_LAT)
  ) u_vpipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (1'b0),
    .i_valid (r_win_valid),
    .o_valid (y_valid),
    .o_empty (w_pipe_empty)
  );

  assign win_valid     = r_win_valid;
  assign coeff_pending = r_pending;

  assign x0 = r_x[0];
  assign x1 = r_x[1];
  assign x2 = r_x[2];
  assign x3 = r_x[3];
  assign x4 = r_x[4];
  assign x5 = r_x[5];
  assign x6 = r_x[6];
  assign x7 = r_x[7];

  assign coeff0 = r_coeff[0];
  assign coeff1 = r_coeff[1];
  assign coeff2 = r_coeff[2];
  assign coeff3 = r_coeff[3];
  assign coeff4 = r_coeff[4];
  assign coeff5 = r_coeff[5];
  assign coeff6 = r_coeff[6];
  assign coeff7 = r_coeff[7];

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Scoreboard bench for fir_sample_feeder: a queue-based window model predicts
// each cycle's outputs; a separate monitor pops and compares them.
module tb_fir_sample_feeder;

  localparam int W  = 16;
  localparam int FW = 8 * W;
`ifdef FIR_FEEDER_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                s_valid = 1'b0;
  logic                coeff_we = 1'b0;
  logic                coeff_commit = 1'b0;
  logic                flush = 1'b0;
  logic [2:0]          coeff_addr = 3'd0;
  logic signed [W-1:0] s_data = '0;
  logic signed [W-1:0] coeff_wdata = '0;

  logic s_ready, coeff_pending, win_valid, y_valid;
  logic signed [W-1:0] x0, x1, x2, x3, x4, x5, x6, x7;
  logic signed [W-1:0] c0, c1, c2, c3, c4, c5, c6, c7;
  logic [FW-1:0] dut_x, dut_c;

  assign dut_x = {x7, x6, x5, x4, x3, x2, x1, x0};
  assign dut_c = {c7, c6, c5, c4, c3, c2, c1, c0};

  fir_sample_feeder #(.bit_width(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata),
    .coeff_commit(coeff_commit), .coeff_pending(coeff_pending), .flush(flush),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
    .coeff0(c0), .coeff1(c1), .coeff2(c2), .coeff3(c3),
    .coeff4(c4), .coeff5(c5), .coeff6(c6), .coeff7(c7),
    .win_valid(win_valid), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            stamp;
    logic          rdy;
    logic          pend;
    logic          wv;
    logic          yv;
    logic [FW-1:0] x;
    logic [FW-1:0] coef;
  } stat_t;

  typedef struct {
    int            stamp;
    logic [FW-1:0] x;
  } win_t;

  stat_t status_q[$];
  win_t  win_q[$];
  int    y_q[$];

  // Reference model: window as a sample history, newest first.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_shadow[8];
  logic [W-1:0] m_active[8];
  bit m_pend, m_flushing, m_clear_due;
  int m_filled, m_silent, m_loud, m_last_wv;

  function automatic logic [FW-1:0] flat_hist();
    logic [FW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*W +: W] = hist[k];
    return r;
  endfunction

  function automatic logic [FW-1:0] flat_active();
    logic [FW-1:0] r;
    for (int k = 0; k < 8; k++) r[k*W +: W] = m_active[k];
    return r;
  endfunction

  task automatic zero_hist();
    hist = {};
    for (int k = 0; k < 8; k++) hist.push_back('0);
  endtask

  task automatic model_reset();
    zero_hist();
    for (int k = 0; k < 8; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_pend = 0; m_flushing = 0; m_clear_due = 0;
    m_filled = 0; m_silent = 0; m_loud = 0; m_last_wv = -100;
  endtask

  task automatic shift_in(input logic [W-1:0] v);
    hist.push_front(v);
    hist = hist[0:7];
  endtask

  task automatic push_status(input int stamp, input bit wv);
    stat_t s;
    s.stamp = stamp;
    s.rdy   = !m_pend && !m_flushing;
    s.pend  = m_pend;
    s.wv    = wv;
    s.yv    = 1'b0;
    foreach (y_q[i]) if (y_q[i] == stamp) s.yv = 1'b1;
    s.x     = flat_hist();
    s.coef  = flat_active();
    status_q.push_back(s);
  endtask

  // Advance the model across the coming rising edge using the driven inputs.
  task automatic model_step();
    int  k;
    bit  ready, acc, copy, pend_old, wv;
    win_t e;
    k        = cyc;
    ready    = !m_pend && !m_flushing;
    acc      = s_valid && ready;
    copy     = m_pend && ((k - m_last_wv) > 4);
    pend_old = m_pend;
    wv       = 0;
    if (coeff_we) m_shadow[coeff_addr] = coeff_wdata;
    if (copy) for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
    m_pend = coeff_commit || (m_pend && !copy);
    if (m_clear_due) begin
      zero_hist();
      m_clear_due = 0;
    end
    if (m_flushing) begin
      if (!pend_old) begin
        shift_in('0);
        if (m_silent > 0) m_silent--;
        else begin
          wv = 1;
          m_loud--;
          if (m_loud == 0) begin
            m_flushing  = 0;
            m_filled    = 0;
            m_clear_due = 1;
          end
        end
      end
    end else begin
      if (acc) begin
        shift_in(s_data);
        m_filled++;
        if (m_filled >= 8) wv = 1;
      end
      if (FLUSH_EN && flush && m_filled > 0) begin
        m_flushing = 1;
        m_silent   = (m_filled >= 8) ? 0 : 8 - m_filled;
        m_loud     = 7;
      end
    end
    if (wv) begin
      e.stamp = k + 1;
      e.x     = flat_hist();
      win_q.push_back(e);
      y_q.push_back(k + 5);
      m_last_wv = k + 1;
    end
    push_status(k + 1, wv);
  endtask

  task automatic drive(input bit sv, input logic [W-1:0] sd, input bit fl, input bit we,
                       input logic [2:0] a, input logic [W-1:0] wd, input bit cm);
    @(negedge clk);
    rst_n = 1'b1; s_valid = sv; s_data = sd; flush = fl;
    coeff_we = we; coeff_addr = a; coeff_wdata = wd; coeff_commit = cm;
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 3'd0, '0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 0; flush = 0; coeff_we = 0; coeff_commit = 0;
    model_reset();
    win_q.delete();
    y_q.delete();
    push_status(cyc + 1, 0);
  endtask

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: one status entry per cycle, window/result entries on strobes.
  initial begin
    stat_t st;
    win_t  we_;
    int    ys;
    forever begin
      @(posedge clk);
      #2;
      if (status_q.size() > 0) begin
        st = status_q.pop_front();
        chk("stamp", FW'(cyc), FW'(st.stamp));
        chk("s_ready", FW'(s_ready), FW'(st.rdy));
        chk("coeff_pending", FW'(coeff_pending), FW'(st.pend));
        chk("win_valid", FW'(win_valid), FW'(st.wv));
        chk("y_valid", FW'(y_valid), FW'(st.yv));
        chk("window", dut_x, st.x);
        chk("coeffs", dut_c, st.coef);
        if (win_valid) begin
          if (win_q.size() == 0) chk("win_unexpected", FW'(1), FW'(0));
          else begin
            we_ = win_q.pop_front();
            chk("win_stamp", FW'(cyc), FW'(we_.stamp));
            chk("win_data", dut_x, we_.x);
          end
        end
        if (y_valid) begin
          if (y_q.size() == 0) chk("y_unexpected", FW'(1), FW'(0));
          else begin
            ys = y_q.pop_front();
            chk("y_stamp", FW'(cyc), FW'(ys));
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    for (int i = 1; i <= 8; i++) drive(1, W'(i), 0, 0, 3'd0, '0, 0);
    for (int i = 9; i <= 12; i++) drive(1, W'(i), 0, 0, 3'd0, '0, 0);
    drive(0, '0, 1, 0, 3'd0, '0, 0);
    idle(12);
    for (int i = 1; i <= 8; i++) drive(1, W'(100 + i), 0, 0, 3'd0, '0, 0);
    drive(1, W'(200), 0, 1, 3'd3, 16'h0100, 0);
    drive(1, W'(201), 0, 0, 3'd0, '0, 1);
    for (int i = 0; i < 14; i++) drive(1, W'(300 + i), 0, 0, 3'd0, '0, 0);
    idle(8);
    drive(0, '0, 0, 0, 3'd0, '0, 1);
    drive(0, '0, 0, 1, 3'd0, 16'h7FFF, 0);
    idle(3);
    for (int i = 1; i <= 8; i++) drive(1, W'(50 + i), 0, 0, 3'd0, '0, 0);
    drive(0, '0, 1, 0, 3'd0, '0, 0);
    idle(3);
    do_reset();
    idle(10);
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 9) < 7, W'($urandom), $urandom_range(0, 99) < 3,
            $urandom_range(0, 9) == 0, 3'($urandom), W'($urandom),
            $urandom_range(0, 99) < 3);
    end
    idle(30);
    @(posedge clk);
    #3;
    chk("win_q_left", FW'(win_q.size()), FW'(0));
    chk("y_q_left", FW'(y_q.size()), FW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
